// File: rtl/tt_um_addon_hypot_pkg.sv
// Shared types and the single-step square-root kernel for the hypotenuse cell.
// The kernel is a pure function so the root engine can chain two steps per clock.
package tt_um_addon_hypot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQ   = 2'd1,
    ST_ROOT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int RAD_W     = 20;
  localparam int ROOT_W    = 10;
  localparam int REM_W     = 12;
  localparam int ITER_W    = 3;
  localparam int ITER_LAST = 4;

  typedef struct packed {
    logic [REM_W-1:0]  rem;
    logic [ROOT_W-1:0] root;
  } sqrt_step_t;

  // One restoring step: bring in one radicand bit pair, decide one root bit.
  // The remainder never exceeds 2*root, so dropping its top two bits on the shift is safe.
  function automatic sqrt_step_t sqrt_step(input logic [REM_W-1:0]  rem,
                                           input logic [ROOT_W-1:0] root,
                                           input logic [1:0]        pair);
    sqrt_step_t       result;
    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] trial;
    shifted = REM_W'({rem, pair});
    trial   = {root, 2'b01};
    if (shifted >= trial) begin
      result.rem  = shifted - trial;
      result.root = ROOT_W'({root, 1'b1});
    end else begin
      result.rem  = shifted;
      result.root = ROOT_W'({root, 1'b0});
    end
    return result;
  endfunction

endpackage

// File: rtl/tt_um_addon_hypot_isqrt_radix4.sv
// Iterative radix-4 integer square root: 20-bit radicand, 10-bit root in five cycles.
// Each cycle retires four radicand bits (two bit pairs) and produces two root bits.
module tt_um_addon_hypot_isqrt_radix4
  import tt_um_addon_hypot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAD_W-1:0]  rad_in,
  output logic [ROOT_W-1:0] root,
  output logic              done
);

  logic [RAD_W-1:0]  rad_q;
  logic [REM_W-1:0]  rem_q;
  logic [ROOT_W-1:0] root_q;
  logic [ITER_W-1:0] iter_q;
  logic              busy_q;
  sqrt_step_t        step_hi;
  sqrt_step_t        step_lo;

  always_comb begin
    step_hi = sqrt_step(rem_q, root_q, rad_q[RAD_W-1:RAD_W-2]);
    step_lo = sqrt_step(step_hi.rem, step_hi.root, rad_q[RAD_W-3:RAD_W-4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rad_q  <= rad_in;
      rem_q  <= '0;
      root_q <= '0;
      iter_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rad_q  <= {rad_q[RAD_W-5:0], 4'b0000};
      rem_q  <= step_lo.rem;
      root_q <= step_lo.root;
      iter_q <= iter_q + 1'b1;
      if (iter_q == ITER_W'(ITER_LAST)) busy_q <= 1'b0;
    end
  end

  // Asserted during the final iteration so the caller can leave ROOT on the same edge.
  assign done = busy_q && (iter_q == ITER_W'(ITER_LAST));
  assign root = root_q;

endmodule

// File: rtl/tt_um_addon_hypot.sv
// Tiny Tapeout cell: uo_out = min(floor(sqrt(ui_in^2 + uio_in^2)), 255), recomputed on any operand change.
// state | meaning: IDLE waits for change / SQ squares operands / ROOT runs the root engine / DONE commits result
module tt_um_addon_hypot
  import tt_um_addon_hypot_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t            state_q;
  state_t            state_next;
  logic [7:0]        x_q;
  logic [7:0]        y_q;
  logic [7:0]        result_q;
  logic              changed;
  logic              load;
  logic              start;
  logic              commit;
  logic [RAD_W-1:0]  sum_sq;
  logic [ROOT_W-1:0] root;
  logic              root_done;
  logic              unused_ena;

  assign unused_ena = ena;
  assign changed    = ({ui_in, uio_in} != {x_q, y_q});
  assign sum_sq     = RAD_W'(x_q) * RAD_W'(x_q) + RAD_W'(y_q) * RAD_W'(y_q);

  always_comb begin
    state_next = state_q;
    load       = 1'b0;
    start      = 1'b0;
    commit     = 1'b0;
    // Any operand change restarts from SQ; a stale root is never committed.
    if (changed) begin
      load       = 1'b1;
      state_next = ST_SQ;
    end else begin
      unique case (state_q)
        ST_IDLE: state_next = ST_IDLE;
        ST_SQ: begin
          start      = 1'b1;
          state_next = ST_ROOT;
        end
        ST_ROOT: if (root_done) state_next = ST_DONE;
        ST_DONE: begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_next;
      if (load) begin
        x_q <= ui_in;
        y_q <= uio_in;
      end
      if (commit) result_q <= (root > ROOT_W'(255)) ? 8'hFF : root[7:0];
    end
  end

  tt_um_addon_hypot_isqrt_radix4 u_isqrt (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .rad_in (sum_sq),
    .root   (root),
    .done   (root_done)
  );

  assign uo_out  = result_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_addon_hypot.sv
// Directed bench for the hypotenuse cell: fixed vectors, restart, mid-run reset, ena sweep.
module tb_tt_um_addon_hypot;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors;
  int miscompares;

  logic [7:0] sweep_x   [16];
  logic [7:0] sweep_y   [16];
  logic [7:0] sweep_res [16];

  tt_um_addon_hypot dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hyp_model(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic apply(input logic [7:0] x, input logic [7:0] y, input logic [7:0] expected,
                       input string tag);
    ui_in  = x;
    uio_in = y;
    repeat (10) @(negedge clk);
    check(tag, uo_out, expected);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ena         = 1'b1;
    ui_in       = 8'd0;
    uio_in      = 8'd0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;

    // reset
    repeat (5) @(negedge clk);
    check("rst_uo_out", uo_out, 8'd0);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_uo_out", uo_out, 8'd0);

    // directed vectors
    apply(8'd3,   8'd4,   8'd5,   "x3_y4");
    apply(8'd6,   8'd8,   8'd10,  "x6_y8");
    apply(8'd10,  8'd10,  8'd14,  "x10_y10");
    apply(8'd12,  8'd16,  8'd20,  "x12_y16");
    apply(8'd255, 8'd255, 8'd255, "x255_y255_sat");
    apply(8'd0,   8'd200, 8'd200, "x0_y200");
    apply(8'd200, 8'd0,   8'd200, "x200_y0");
    apply(8'd0,   8'd0,   8'd0,   "x0_y0");
    apply(8'd1,   8'd1,   8'd1,   "x1_y1");
    apply(8'd180, 8'd180, 8'd254, "x180_y180");
    apply(8'd181, 8'd181, 8'd255, "x181_y181_sat");
    apply(8'd1,   8'd1,   8'd1,   "x1_y1_again");
    check("uio_oe_idle", uio_oe, 8'h00);
    check("uio_out_idle", uio_out, 8'h00);

    // restart: abort 3,4 after three edges, result must go 1 -> 13 without ever showing 5
    ui_in  = 8'd3;
    uio_in = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("restart_hold_old", uo_out, 8'd1);
    end
    ui_in  = 8'd5;
    uio_in = 8'd12;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("restart_before_commit", uo_out, 8'd1);
    end
    @(negedge clk);
    check("restart_result_13", uo_out, 8'd13);

    // exact latency on a fresh computation
    ui_in  = 8'd12;
    uio_in = 8'd16;
    repeat (7) @(negedge clk);
    check("latency_edge7_old", uo_out, 8'd13);
    @(negedge clk);
    check("latency_edge8_new", uo_out, 8'd20);

    // reset mid-computation discards everything, then recomputes the held operands
    ui_in  = 8'd6;
    uio_in = 8'd8;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_uo_out", uo_out, 8'd0);
    repeat (2) @(negedge clk);
    check("midrun_rst_hold", uo_out, 8'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("after_midrun_rst", uo_out, 8'd10);

    // random sweep with ena high, then the same operands with ena low
    for (int i = 0; i < 16; i++) begin
      sweep_x[i]   = 8'($urandom_range(0, 255));
      sweep_y[i]   = 8'($urandom_range(0, 255));
      sweep_res[i] = hyp_model(int'(sweep_x[i]), int'(sweep_y[i]));
      apply(sweep_x[i], sweep_y[i], sweep_res[i], "sweep_ena1");
    end
    ena = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      apply(sweep_x[i], sweep_y[i], sweep_res[i], "sweep_ena0");
    end
    apply(8'd3, 8'd4, 8'd5, "ena0_x3_y4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
